// File: rtl/stereo_sad_engine.sv
// Stereo block-matching engine: loads an L/R frame pair, then streams a
// zero-padded SAD disparity map with per-pixel best cost.
module stereo_sad_engine #(
  parameter int IMG_W      = 20,
  parameter int IMG_H      = 7,
  parameter int PIX_W      = 8,
  parameter int HALF_BLOCK = 2,
  parameter int MAX_DISP   = 14,
  parameter int DISP_W     = 4,
  localparam int N         = 2*HALF_BLOCK+1,
  localparam int N2        = N*N,
  localparam int COST_W    = PIX_W + $clog2(N2),
  localparam int XW        = $clog2(IMG_W),
  localparam int YW        = $clog2(IMG_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PIX_W-1:0]  in_left,
  input  logic [PIX_W-1:0]  in_right,
  input  logic [COST_W-1:0] cost_thresh,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DISP_W-1:0] out_disp,
  output logic [COST_W-1:0] out_cost,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic              out_last
);

  localparam int DEPTH = IMG_W*IMG_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int WW    = $clog2(N+1);
  localparam int CNW   = $clog2(N2+1);
  localparam int SW    = $clog2(DEPTH+IMG_W+MAX_DISP+N)+2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;

  logic [2:0]        state;
  logic [XW-1:0]     x, nx, ix;
  logic [YW-1:0]     y, ny, iy;
  logic [DISP_W-1:0] d, id, best_d;
  logic [WW-1:0]     wx, wy;
  logic [CNW-1:0]    acc_cnt;
  logic [AW-1:0]     wr_addr, l_addr, r_addr;
  logic [COST_W-1:0] sum, sum_next, best_cost, thresh;
  logic [PIX_W-1:0]  lmem [DEPTH];
  logic [PIX_W-1:0]  rmem [DEPTH];
  logic [PIX_W-1:0]  l_q, r_q, tv, cv, ad;
  logic              l_ok, r_ok, l_in, r_in;
  logic signed [SW-1:0] lx, ly, rx;

  logic fire_in, fire_out, load_end, last_pix;
  logic acc_end, more_d, issue;

  assign fire_in  = in_valid && in_ready;
  assign fire_out = out_valid && out_ready;
  assign load_end = fire_in && (wr_addr == AW'(DEPTH-1));
  assign last_pix = (x == XW'(IMG_W-1)) && (y == YW'(IMG_H-1));
  assign acc_end  = acc_cnt == CNW'(N2-1);
  assign more_d   = d != DISP_W'(MAX_DISP);

  // A read is issued one cycle ahead of each accumulate, so the
  // first offset of a candidate goes out from the preceding state.
  assign issue = (state == S_LOAD  && load_end)
              || (state == S_ACCUM && !acc_end)
              || (state == S_CMP   && more_d)
              || (state == S_EMIT  && fire_out && !last_pix);

  always_comb begin
    nx = x + 1'b1;
    ny = y;
    if (x == XW'(IMG_W-1)) begin
      nx = '0;
      ny = y + 1'b1;
    end
  end

  always_comb begin
    ix = x;
    iy = y;
    id = d;
    if (state == S_CMP) begin
      id = d + 1'b1;
    end else if (state == S_EMIT) begin
      ix = nx;
      iy = ny;
      id = '0;
    end
  end

  always_comb begin
    lx = SW'(ix) + SW'(wx) - SW'(HALF_BLOCK);
    ly = SW'(iy) + SW'(wy) - SW'(HALF_BLOCK);
    rx = lx - SW'(id);
    l_in = !lx[SW-1] && (lx < $signed(SW'(IMG_W)))
        && !ly[SW-1] && (ly < $signed(SW'(IMG_H)));
    r_in = !rx[SW-1] && (rx < $signed(SW'(IMG_W)))
        && !ly[SW-1] && (ly < $signed(SW'(IMG_H)));
    l_addr = l_in ? AW'(ly * $signed(SW'(IMG_W)) + lx) : '0;
    r_addr = r_in ? AW'(ly * $signed(SW'(IMG_W)) + rx) : '0;
  end

  always_ff @(posedge clk) begin
    if (fire_in) begin
      lmem[wr_addr] <= in_left;
      rmem[wr_addr] <= in_right;
    end
    l_q <= lmem[l_addr];
    r_q <= rmem[r_addr];
  end

  always_comb begin
    tv = l_ok ? l_q : '0;
    cv = r_ok ? r_q : '0;
    ad = (tv >= cv) ? tv - cv : cv - tv;
    sum_next = (acc_cnt == '0 ? '0 : sum) + COST_W'(ad);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      x         <= '0;
      y         <= '0;
      d         <= '0;
      wx        <= '0;
      wy        <= '0;
      acc_cnt   <= '0;
      wr_addr   <= '0;
      sum       <= '0;
      best_cost <= '0;
      best_d    <= '0;
      thresh    <= '0;
      done      <= 1'b0;
      l_ok      <= 1'b0;
      r_ok      <= 1'b0;
    end else begin
      done <= 1'b0;
      l_ok <= l_in;
      r_ok <= r_in;
      if (issue) begin
        if (wx == WW'(N-1)) begin
          wx <= '0;
          wy <= (wy == WW'(N-1)) ? '0 : wy + 1'b1;
        end else begin
          wx <= wx + 1'b1;
        end
      end
      unique case (state)
        S_IDLE: begin
          x       <= '0;
          y       <= '0;
          d       <= '0;
          wx      <= '0;
          wy      <= '0;
          acc_cnt <= '0;
          wr_addr <= '0;
          if (start && !done) begin
            thresh <= cost_thresh;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (fire_in) wr_addr <= wr_addr + 1'b1;
          if (load_end) state <= S_ACCUM;
        end
        S_ACCUM: begin
          sum     <= sum_next;
          acc_cnt <= acc_end ? '0 : acc_cnt + 1'b1;
          if (acc_end) state <= S_CMP;
        end
        S_CMP: begin
          if (d == '0 || sum < best_cost) begin
            best_cost <= sum;
            best_d    <= d;
          end
          sum <= '0;
          if (more_d) begin
            d     <= d + 1'b1;
            state <= S_ACCUM;
          end else begin
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (fire_out) begin
            if (last_pix) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end else begin
              x     <= nx;
              y     <= ny;
              d     <= '0;
              state <= S_ACCUM;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = state != S_IDLE;
  assign in_ready  = state == S_LOAD;
  assign out_valid = state == S_EMIT;
  assign out_disp  = (best_cost > thresh) ? '1 : best_d;
  assign out_cost  = best_cost;
  assign out_x     = x;
  assign out_y     = y;
  assign out_last  = out_valid && last_pix;

endmodule

// File: tb/tb_stereo_sad_engine.sv
// Scoreboard bench for stereo_sad_engine: a reference SAD model fills the
// expected queue at load time; results are popped on each output accept.
module tb_stereo_sad_engine;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int HB = 1;
  localparam int MD = 3;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_left = '0;
  logic [7:0]    in_right = '0;
  logic [CW-1:0] cost_thresh = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2:0]    out_disp;
  logic [CW-1:0] out_cost;
  logic [2:0]    out_x;
  logic [1:0]    out_y;
  logic          out_last;

  stereo_sad_engine #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8),
    .HALF_BLOCK(HB), .MAX_DISP(MD), .DISP_W(3)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right),
    .cost_thresh(cost_thresh),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_disp(out_disp), .out_cost(out_cost),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int disp;
    int cost;
    int last;
  } exp_t;

  exp_t q[$];
  int lf [H][W];
  int rf [H][W];
  int got_disp [H][W];
  int got_cost [H][W];
  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int px(input bit left, input int xx, input int yy);
    if (xx < 0 || xx >= W || yy < 0 || yy >= H) return 0;
    return left ? lf[yy][xx] : rf[yy][xx];
  endfunction

  task automatic build_expect(input int th);
    exp_t e;
    for (int yy = 0; yy < H; yy++) begin
      for (int xx = 0; xx < W; xx++) begin
        int best, bd;
        best = 0;
        bd = 0;
        for (int dd = 0; dd <= MD; dd++) begin
          int s;
          s = 0;
          for (int dy = -HB; dy <= HB; dy++)
            for (int dx = -HB; dx <= HB; dx++) begin
              int a, b;
              a = px(1'b1, xx+dx, yy+dy);
              b = px(1'b0, xx-dd+dx, yy+dy);
              s += (a > b) ? a - b : b - a;
            end
          if (dd == 0 || s < best) begin
            best = s;
            bd = dd;
          end
        end
        e.x = xx;
        e.y = yy;
        e.cost = best;
        e.disp = (best > th) ? 7 : bd;
        e.last = (xx == W-1 && yy == H-1) ? 1 : 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic load_frame(input int th, input bit stall);
    int i, cyc;
    bit v, rdy;
    build_expect(th);
    @(negedge clk);
    start = 1'b1;
    cost_thresh = CW'(th);
    @(negedge clk);
    start = 1'b0;
    i = 0;
    cyc = 0;
    while (i < W*H && cyc < 2000) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_left  = 8'(lf[i/W][i%W]);
      in_right = 8'(rf[i/W][i%W]);
      rdy = in_ready;
      @(negedge clk);
      cyc++;
      if (v && rdy) i++;
    end
    in_valid = 1'b0;
    chk("load_count", i, W*H);
    chk("in_ready_fall", int'(in_ready), 0);
  endtask

  task automatic collect(input bit bp, input int stop_after);
    int lat, cyc, k, last_acc;
    bit held;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 500) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency", lat, (MD+1)*(9+1));
    cyc = 0;
    k = 0;
    last_acc = 0;
    held = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && cyc < 5000) begin
      if (out_valid) begin
        if (bp && k == 5 && !held) begin
          held = 1'b1;
          out_ready = 1'b0;
          e = q[0];
          repeat (10) begin
            @(negedge clk);
            cyc++;
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_disp", int'(out_disp), e.disp);
            chk("hold_cost", int'(out_cost), e.cost);
            chk("hold_x", int'(out_x), e.x);
          end
          out_ready = 1'b1;
        end
        e = q.pop_front();
        chk("disp", int'(out_disp), e.disp);
        chk("cost", int'(out_cost), e.cost);
        chk("x", int'(out_x), e.x);
        chk("y", int'(out_y), e.y);
        chk("last", int'(out_last), e.last);
        got_disp[e.y][e.x] = int'(out_disp);
        got_cost[e.y][e.x] = int'(out_cost);
        if (k == 1 && !bp) chk("pixel_rate", cyc - last_acc, (MD+1)*10+1);
        last_acc = cyc;
        k++;
        @(negedge clk);
        cyc++;
        if (k == 1) chk("valid_drop", int'(out_valid), 0);
        if (k == stop_after) return;
        if (q.size() == 0) begin
          chk("done_pulse", int'(done), 1);
          chk("idle_busy", int'(busy), 0);
          @(negedge clk);
          chk("done_once", int'(done), 0);
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("collect_left", q.size(), 0);
  endtask

  task automatic frame_random_same();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        lf[yy][xx] = $urandom_range(0, 255);
        rf[yy][xx] = lf[yy][xx];
      end
  endtask

  task automatic frame_shift();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        lf[yy][xx] = 16*xx + 1;
        rf[yy][xx] = (xx+2 < W) ? 16*(xx+2) + 1 : 0;
      end
  endtask

  task automatic frame_fill(input int l, input int r);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        lf[yy][xx] = l;
        rf[yy][xx] = r;
      end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_disp", int'(out_disp), 0);
    chk("rst_cost", int'(out_cost), 0);
    chk("rst_x", int'(out_x), 0);
    chk("rst_y", int'(out_y), 0);
    chk("rst_last", int'(out_last), 0);
    reset = 1'b0;

    frame_random_same();
    load_frame(4095, 1'b0);
    collect(1'b0, -1);
    for (int xx = 0; xx < W; xx++) begin
      chk("same_disp", got_disp[2][xx], 0);
      chk("same_cost", got_cost[2][xx], 0);
    end

    load_frame(4095, 1'b1);
    collect(1'b1, -1);

    frame_shift();
    load_frame(4095, 1'b0);
    collect(1'b0, -1);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 3; xx <= 5; xx++) begin
        chk("shift_disp", got_disp[yy][xx], 2);
        chk("shift_cost", got_cost[yy][xx], 0);
      end

    frame_fill(8'h40, 8'h40);
    load_frame(4095, 1'b0);
    collect(1'b0, -1);
    chk("tie_disp", got_disp[1][4], 0);
    chk("tie_cost", got_cost[1][4], 0);

    frame_fill(8'hFF, 8'h00);
    load_frame(100, 1'b0);
    collect(1'b0, -1);
    chk("thr_disp_corner", got_disp[0][0], 7);
    chk("thr_disp_int", got_disp[2][5], 7);
    chk("thr_cost_int", got_cost[1][1], 2295);

    frame_shift();
    load_frame(4095, 1'b0);
    collect(1'b0, 19);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    q.delete();

    frame_random_same();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 1; xx < W; xx++)
        rf[yy][xx-1] = lf[yy][xx];
    load_frame(4095, 1'b1);
    collect(1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
